// File: rtl/signed_mul_seq_pkg.sv
// Shared definitions for the sequential signed multiplier: FSM state encoding
// and the default operand width.
package signed_mul_seq_pkg;

  localparam int W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_MUL  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/signed_mul_seq_if.sv
// Start/busy/done handshake bundle between the control unit (master) and the
// multiplier (slave).
interface signed_mul_seq_if #(
  parameter int W = 8
) ();
  // start is sampled only while busy is low; done pulses for one cycle with
  // product valid, and product holds until the next operation's FIX state.
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/signed_mul_seq_datapath.sv
// Operand registers, magnitude conversion, shared W-bit adder, shift-add
// accumulator and final sign fix-up for the sequential signed multiplier.
module signed_mul_seq_datapath #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_cap,
  input  logic           i_ld,
  input  logic           i_mul,
  input  logic           i_fix,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic [2*W-1:0] o_product
);

  localparam logic [W-1:0]   ONE_W  = W'(1);
  localparam logic [2*W-1:0] ONE_2W = (2*W)'(1);

  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_mcand;
  logic [W-1:0]   r_acc;
  logic [W-1:0]   r_mq;
  logic           r_neg;
  logic [2*W-1:0] r_product;

  logic [W-1:0]   w_add_x;
  logic [W-1:0]   w_add_y;
  logic           w_cin;
  logic [W:0]     w_sum;
  logic [W-1:0]   w_b_mag;
  logic [2*W-1:0] w_full;

  // The adder negates the multiplicand during LOAD (~a + 1) and accumulates
  // during MUL; the carry out lands in w_sum[W] and is shifted straight in.
  assign w_add_x = i_ld ? ~r_a : r_acc;
  assign w_add_y = i_ld ? '0 : (r_mq[0] ? r_mcand : '0);
  assign w_cin   = i_ld;
  assign w_sum   = {1'b0, w_add_x} + {1'b0, w_add_y} + {{W{1'b0}}, w_cin};

  assign w_b_mag = r_b[W-1] ? (~r_b + ONE_W) : r_b;
  assign w_full  = {r_acc, r_mq};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mq      <= '0;
      r_neg     <= 1'b0;
      r_product <= '0;
    end else begin
      if (i_cap) begin
        r_a <= i_a;
        r_b <= i_b;
      end
      if (i_ld) begin
        r_mcand <= r_a[W-1] ? w_sum[W-1:0] : r_a;
        r_mq    <= w_b_mag;
        r_neg   <= r_a[W-1] ^ r_b[W-1];
        r_acc   <= '0;
      end else if (i_mul) begin
        r_acc <= w_sum[W:1];
        r_mq  <= {w_sum[0], r_mq[W-1:1]};
      end
      if (i_fix) begin
        r_product <= r_neg ? (~w_full + ONE_2W) : w_full;
      end
    end
  end

  assign o_product = r_product;

endmodule

// File: rtl/signed_mul_seq.sv
// Sequential signed multiplier top: FSM, iteration counter and handshake,
// driving the shift-add datapath through ld/mul/fix strobes.
module signed_mul_seq
  import signed_mul_seq_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  signed_mul_seq_if.slave  bus,
  output state_t           o_dbg_state
);

  localparam int                CNT_W    = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_n;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cap;
  logic             w_ld;
  logic             w_mul;
  logic             w_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cap     = 1'b0;
    w_ld      = 1'b0;
    w_mul     = 1'b0;
    w_fix     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_cap     = 1'b1;
          w_state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        w_ld      = 1'b1;
        w_state_n = S_MUL;
      end
      S_MUL: begin
        w_mul = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_state_n = S_FIX;
        end
      end
      S_FIX: begin
        w_fix     = 1'b1;
        w_state_n = S_DONE;
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_ld) begin
      r_cnt <= '0;
    end else if (w_mul) begin
      r_cnt <= r_cnt + ONE_CNT;
    end
  end

  signed_mul_seq_datapath #(.W(W)) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .i_cap     (w_cap),
    .i_ld      (w_ld),
    .i_mul     (w_mul),
    .i_fix     (w_fix),
    .i_a       (bus.a),
    .i_b       (bus.b),
    .o_product (bus.product)
  );

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = (r_state == S_DONE);
  assign o_dbg_state = r_state;

endmodule
